// File: rtl/ps2_pkg.sv
// Shared scancode constants and FSM state encoding for the PS/2 key event scheduler.
package ps2_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_TAB    = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_PUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational set-2 scancode to ASCII translation; returns 0 for unmapped codes.
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic       shift_i,
  input  logic       caps_i,
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  logic [7:0] base;
  logic [7:0] alt;
  logic       letter;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    base = 8'h00;
    alt  = 8'h00;
    case (code_i)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
      8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
      8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
      8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
      8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h16: {base, alt} = {"1", "!"};
      8'h1E: {base, alt} = {"2", "@"};
      8'h26: {base, alt} = {"3", "#"};
      8'h25: {base, alt} = {"4", "$"};
      8'h2E: {base, alt} = {"5", "%"};
      8'h36: {base, alt} = {"6", "^"};
      8'h3D: {base, alt} = {"7", "&"};
      8'h3E: {base, alt} = {"8", "*"};
      8'h46: {base, alt} = {"9", "("};
      8'h45: {base, alt} = {"0", ")"};
      8'h4E: {base, alt} = {"-", "_"};
      8'h55: {base, alt} = {"=", "+"};
      8'h54: {base, alt} = {"[", "{"};
      8'h5B: {base, alt} = {"]", "}"};
      8'h5D: {base, alt} = {"\\", "|"};
      8'h4C: {base, alt} = {";", ":"};
      8'h52: {base, alt} = {"'", "\""};
      8'h41: {base, alt} = {",", "<"};
      8'h49: {base, alt} = {".", ">"};
      8'h4A: {base, alt} = {"/", "?"};
      8'h0E: {base, alt} = {8'h60, "~"};
      SC_SPACE: base = 8'h20;
      SC_ENTER: base = 8'h0D;
      SC_BKSP:  base = 8'h08;
      SC_TAB:   base = 8'h09;
      default:  base = 8'h00;
    endcase
  end

  assign letter = (base >= 8'h61) && (base <= 8'h7A);

  // Letters honour caps-lock; everything else only follows shift, and keys without a shifted form keep their base code.
  always_comb begin
    if (letter)
      ascii_o = (shift_i ^ caps_i) ? (base - 8'h20) : base;
    else if (shift_i && (alt != 8'h00))
      ascii_o = alt;
    else
      ascii_o = base;
  end

endmodule

// File: rtl/ps2_key_event_scheduler.sv
// Translates PS/2 make/break events into ASCII, queues them in a FIFO and throttles the receiver.
module ps2_key_event_scheduler
  import ps2_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int RX_MARGIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_tick,
  input  logic       key_make,
  input  logic [7:0] key_code,
  output logic       rx_en,
  output logic       char_valid,
  output logic [7:0] char_data,
  input  logic       char_ready,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    RX_LIMIT = (AW + 1)'(DEPTH - RX_MARGIN);

  state_e      state_q, state_d;
  logic        ev_make_q, ev_make_d;
  logic [7:0]  ev_code_q, ev_code_d;
  logic        lshift_q, lshift_d;
  logic        rshift_q, rshift_d;
  logic        caps_lock_q, caps_lock_d;
  logic        caps_held_q, caps_held_d;
  logic [7:0]  char_q, char_d;
  logic        overflow_q, overflow_d;
  logic        rx_en_q, rx_en_d;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem [DEPTH];

  logic [7:0]  rom_ascii;
  logic [AW:0] count, count_next;
  logic        full, push, pop;

  ps2_ascii_rom u_rom (
    .shift_i (lshift_q | rshift_q),
    .caps_i  (caps_lock_q),
    .code_i  (ev_code_q),
    .ascii_o (rom_ascii)
  );

  // Pointers carry one extra bit so full and empty are distinguishable by subtraction alone.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign full       = (count == FULL_CNT);
  assign char_valid = (count != '0);
  assign pop        = char_valid && char_ready;
  assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
  assign rx_en_d    = (count_next < RX_LIMIT);

  always_comb begin
    state_d     = state_q;
    ev_make_d   = ev_make_q;
    ev_code_d   = ev_code_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_lock_d = caps_lock_q;
    caps_held_d = caps_held_q;
    char_d      = char_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_tick) begin
          ev_make_d = key_make;
          ev_code_d = key_code;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_IDLE;
        case (ev_code_q)
          SC_LSHIFT: lshift_d = ev_make_q;
          SC_RSHIFT: rshift_d = ev_make_q;
          SC_CAPS: begin
            // Typematic repeats arrive as further makes while held; only the first toggles.
            if (!ev_make_q) begin
              caps_held_d = 1'b0;
            end else if (!caps_held_q) begin
              caps_lock_d = ~caps_lock_q;
              caps_held_d = 1'b1;
            end
          end
          default: begin
            if (ev_make_q) begin
              char_d = rom_ascii;
              if (rom_ascii != 8'h00) state_d = S_PUSH;
            end
          end
        endcase
      end
      S_PUSH: begin
        state_d = S_IDLE;
        if (full && !pop) overflow_d = 1'b1;
        else              push       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ev_make_q   <= 1'b0;
      ev_code_q   <= 8'h00;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_held_q <= 1'b0;
      char_q      <= 8'h00;
      overflow_q  <= 1'b0;
      rx_en_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ev_make_q   <= ev_make_d;
      ev_code_q   <= ev_code_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_lock_q <= caps_lock_d;
      caps_held_q <= caps_held_d;
      char_q      <= char_d;
      overflow_q  <= overflow_d;
      rx_en_q     <= rx_en_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= char_q;
  end

  assign char_data = char_valid ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign rx_en     = rx_en_q;
  assign caps_lock = caps_lock_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_scheduler.sv
// Scoreboard bench: expected ASCII is queued as keys are sent and checked as the consumer pops.
module tb_ps2_key_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_tick;
  logic       key_make;
  logic [7:0] key_code;
  logic       rx_en;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       caps_lock;
  logic       overflow;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_key_event_scheduler #(.DEPTH(8), .RX_MARGIN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_tick   (key_tick),
    .key_make   (key_make),
    .key_code   (key_code),
    .rx_en      (rx_en),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .caps_lock  (caps_lock),
    .overflow   (overflow)
  );

  // Inputs change #1 after posedge, so a negedge sample reflects exactly what the next edge will consume.
  always @(negedge clk) begin
    if (!reset && char_valid && char_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pop_unexpected: got char 0x%02h, expected no character", char_data);
      end else begin
        logic [7:0] exp;
        exp = exp_q.pop_front();
        if (char_data !== exp) begin
          tests_failed++;
          $display("FAIL pop_data: got 0x%02h, expected 0x%02h", char_data, exp);
        end
      end
    end
  end

  task automatic expect_bit(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic send(input logic mk, input logic [7:0] code);
    @(posedge clk); #1;
    key_tick = 1'b1;
    key_make = mk;
    key_code = code;
    @(posedge clk); #1;
    key_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    char_ready = 1'b1;
    while ((exp_q.size() != 0 || char_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (cyc >= 100) begin
      tests_failed++;
      $display("FAIL %s_drain_timeout: %0d chars still expected, char_valid=%b", name, exp_q.size(), char_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_tick = 1'b0; key_make = 1'b0; key_code = 8'h00; char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_bit("reset_rx_en", rx_en, 1'b1);
    expect_bit("reset_char_valid", char_valid, 1'b0);
    expect_bit("reset_caps_lock", caps_lock, 1'b0);
    expect_bit("reset_overflow", overflow, 1'b0);
    tests_run++;
    if (char_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_char_data: got 0x%02h, expected 0x00", char_data);
    end
  endtask

  task automatic test_latency();
    char_ready = 1'b0;
    exp_q.push_back(8'h61);
    @(posedge clk); #1;
    key_tick = 1'b1; key_make = 1'b1; key_code = 8'h1C;
    @(posedge clk); #1;
    key_tick = 1'b0;
    expect_bit("lat_cycle1_valid", char_valid, 1'b0);
    @(posedge clk); #1;
    expect_bit("lat_cycle2_valid", char_valid, 1'b0);
    @(posedge clk); #1;
    expect_bit("lat_cycle3_valid", char_valid, 1'b1);
    wait_drain("latency");
  endtask

  task automatic test_basic();
    char_ready = 1'b1;
    exp_q.push_back(8'h61);
    send(1'b1, 8'h1C);
    send(1'b0, 8'h1C);
    send(1'b1, 8'h29); exp_q.push_back(8'h20);
    send(1'b1, 8'h5A); exp_q.push_back(8'h0D);
    send(1'b1, 8'h07);
    wait_drain("basic");
  endtask

  task automatic test_shift();
    char_ready = 1'b1;
    send(1'b1, 8'h12);
    exp_q.push_back(8'h41); send(1'b1, 8'h1C);
    exp_q.push_back(8'h40); send(1'b1, 8'h1E);
    send(1'b0, 8'h12);
    exp_q.push_back(8'h61); send(1'b1, 8'h1C);
    send(1'b1, 8'h59);
    exp_q.push_back(8'h3F); send(1'b1, 8'h4A);
    send(1'b0, 8'h59);
    wait_drain("shift");
  endtask

  task automatic test_caps();
    char_ready = 1'b1;
    repeat (3) send(1'b1, 8'h58);
    send(1'b0, 8'h58);
    expect_bit("caps_after_repeats", caps_lock, 1'b1);
    exp_q.push_back(8'h41); send(1'b1, 8'h1C);
    send(1'b1, 8'h12);
    exp_q.push_back(8'h61); send(1'b1, 8'h1C);
    exp_q.push_back(8'h21); send(1'b1, 8'h16);
    send(1'b0, 8'h12);
    exp_q.push_back(8'h31); send(1'b1, 8'h16);
    send(1'b1, 8'h58);
    send(1'b0, 8'h58);
    expect_bit("caps_toggled_off", caps_lock, 1'b0);
    wait_drain("caps");
  endtask

  task automatic test_fill_overflow();
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h61);
      send(1'b1, 8'h1C);
      expect_bit($sformatf("fill_rx_en_%0d", i + 1), rx_en, (i + 1) < 6);
    end
    expect_bit("fill_overflow_before", overflow, 1'b0);
    send(1'b1, 8'h32);
    expect_bit("fill_overflow_after", overflow, 1'b1);
    expect_bit("fill_rx_en_full", rx_en, 1'b0);
    wait_drain("fill");
    expect_bit("drain_rx_en", rx_en, 1'b1);
    expect_bit("drain_overflow_sticky", overflow, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [8];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    do_reset();
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      send(1'b1, codes[i]);
    end
    exp_q.push_back(8'h69);
    @(posedge clk); #1;
    key_tick = 1'b1; key_make = 1'b1; key_code = 8'h43;
    @(posedge clk); #1;
    key_tick = 1'b0;
    @(posedge clk); #1;
    char_ready = 1'b1;
    @(posedge clk); #1;
    char_ready = 1'b0;
    expect_bit("b2b_overflow", overflow, 1'b0);
    expect_bit("b2b_still_valid", char_valid, 1'b1);
    expect_bit("b2b_rx_en", rx_en, 1'b0);
    tests_run++;
    if (char_data !== 8'h62) begin
      tests_failed++;
      $display("FAIL b2b_head: got 0x%02h, expected 0x62", char_data);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_push();
    do_reset();
    char_ready = 1'b1;
    send(1'b1, 8'h58);
    send(1'b0, 8'h58);
    expect_bit("midrst_caps_set", caps_lock, 1'b1);
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41);
      send(1'b1, 8'h1C);
    end
    @(posedge clk); #1;
    key_tick = 1'b1; key_make = 1'b1; key_code = 8'h32;
    @(posedge clk); #1;
    key_tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    expect_bit("midrst_char_valid", char_valid, 1'b0);
    expect_bit("midrst_rx_en", rx_en, 1'b1);
    expect_bit("midrst_caps_lock", caps_lock, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    expect_bit("midrst_no_late_push", char_valid, 1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_shift();
    test_caps();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
